// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Two-port round-robin arbiter for a line-wide memory, with a grant timeout.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 256,
    parameter int TIMEOUT = 31
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              p0_enable_i,
    input  logic              p0_write_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic [DATA_W-1:0] p0_data_i,
    output logic              p0_ack_o,
    output logic [DATA_W-1:0] p0_data_o,
    input  logic              p1_enable_i,
    input  logic              p1_write_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [DATA_W-1:0] p1_data_i,
    output logic              p1_ack_o,
    output logic [DATA_W-1:0] p1_data_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic              timeout_o,
    output logic [7:0]        timeout_cnt_o
);

    localparam logic [1:0] C_ST_IDLE   = 2'd0;
    localparam logic [1:0] C_ST_GRANT0 = 2'd1;
    localparam logic [1:0] C_ST_GRANT1 = 2'd2;
    localparam logic [7:0] C_CNT_LAST  = 8'(TIMEOUT - 1);

    logic [1:0]        state_q, state_d;
    logic              last1_q;
    logic [7:0]        cnt_q;
    logic [7:0]        tcnt_q;
    logic              timeout_q;
    logic              mem_enable_q;
    logic              mem_write_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_data_q;

    logic w_in_grant;
    logic w_pick1;
    logic w_timeout;

    assign w_in_grant = (state_q == C_ST_GRANT0) || (state_q == C_ST_GRANT1);
    // last1_q high means port 1 held the most recent grant, so port 0 wins a tie
    assign w_pick1    = p1_enable_i && (!p0_enable_i || !last1_q);
    assign w_timeout  = w_in_grant && !mem_ack_i && (cnt_q == C_CNT_LAST);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= C_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            C_ST_IDLE: begin
                if (p0_enable_i || p1_enable_i) begin
                    state_d = w_pick1 ? C_ST_GRANT1 : C_ST_GRANT0;
                end
            end
            C_ST_GRANT0, C_ST_GRANT1: begin
                if (mem_ack_i || w_timeout) begin
                    state_d = C_ST_IDLE;
                end
            end
            default: state_d = C_ST_IDLE;
        endcase
    end

    always_comb begin
        p0_ack_o = 1'b0;
        p1_ack_o = 1'b0;
        case (state_q)
            C_ST_GRANT0: p0_ack_o = mem_ack_i;
            C_ST_GRANT1: p1_ack_o = mem_ack_i;
            default: ;
        endcase
    end

    assign p0_data_o = mem_data_i;
    assign p1_data_o = mem_data_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            last1_q      <= 1'b1;
            cnt_q        <= 8'd0;
            tcnt_q       <= 8'd0;
            timeout_q    <= 1'b0;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
        end else begin
            timeout_q <= w_timeout;
            if (w_timeout && (tcnt_q != 8'hFF)) begin
                tcnt_q <= tcnt_q + 8'd1;
            end
            if (state_q == C_ST_IDLE) begin
                if (state_d != C_ST_IDLE) begin
                    mem_enable_q <= 1'b1;
                    last1_q      <= w_pick1;
                    cnt_q        <= 8'd0;
                    mem_write_q  <= w_pick1 ? p1_write_i : p0_write_i;
                    mem_addr_q   <= w_pick1 ? p1_addr_i  : p0_addr_i;
                    mem_data_q   <= w_pick1 ? p1_data_i  : p0_data_i;
                end
            end else if (state_d == C_ST_IDLE) begin
                mem_enable_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    assign mem_enable_o  = mem_enable_q;
    assign mem_write_o   = mem_write_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_data_o    = mem_data_q;
    assign timeout_o     = timeout_q;
    assign timeout_cnt_o = tcnt_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Scoreboard bench for mem_arbiter: expected grants/acks/timeouts are queued by
// the stimulus and consumed by an independent monitor.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    localparam int K_G = 0;
    localparam int K_A = 1;
    localparam int K_T = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         p0_en, p0_wr, p1_en, p1_wr;
    logic [31:0]  p0_addr, p1_addr;
    logic [255:0] p0_wdata, p1_wdata, mem_rdata;
    logic         resp_ack, stray_ack, mem_ack;
    int           ack_lat;

    logic         a0, a1, m_en, m_wr, tmo;
    logic [31:0]  m_addr;
    logic [255:0] d0, d1, m_wdata;
    logic [7:0]   tcnt;

    logic         t_en, t_ack;
    logic         t_a0, t_a1, t_men, t_mwr, t_tmo;
    logic [31:0]  t_maddr;
    logic [255:0] t_d0, t_d1, t_mdata;
    logic [7:0]   t_cnt;

    typedef struct {
        int           kind;
        int           port;
        logic [31:0]  addr;
        logic         wr;
        logic [255:0] data;
        int           cnt;
    } ev_t;
    ev_t sb[$];

    int n_chk  = 0;
    int n_fail = 0;

    assign mem_ack = resp_ack | stray_ack;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk_i(clk), .rst_i(rst_n),
        .p0_enable_i(p0_en), .p0_write_i(p0_wr), .p0_addr_i(p0_addr), .p0_data_i(p0_wdata),
        .p0_ack_o(a0), .p0_data_o(d0),
        .p1_enable_i(p1_en), .p1_write_i(p1_wr), .p1_addr_i(p1_addr), .p1_data_i(p1_wdata),
        .p1_ack_o(a1), .p1_data_o(d1),
        .mem_enable_o(m_en), .mem_write_o(m_wr), .mem_addr_o(m_addr), .mem_data_o(m_wdata),
        .mem_data_i(mem_rdata), .mem_ack_i(mem_ack),
        .timeout_o(tmo), .timeout_cnt_o(tcnt)
    );

    mem_arbiter #(.TIMEOUT(4)) u_t4 (
        .clk_i(clk), .rst_i(rst_n),
        .p0_enable_i(t_en), .p0_write_i(1'b0), .p0_addr_i(32'h0000_0C00), .p0_data_i(256'd0),
        .p0_ack_o(t_a0), .p0_data_o(t_d0),
        .p1_enable_i(1'b0), .p1_write_i(1'b0), .p1_addr_i(32'd0), .p1_data_i(256'd0),
        .p1_ack_o(t_a1), .p1_data_o(t_d1),
        .mem_enable_o(t_men), .mem_write_o(t_mwr), .mem_addr_o(t_maddr), .mem_data_o(t_mdata),
        .mem_data_i(mem_rdata), .mem_ack_i(t_ack),
        .timeout_o(t_tmo), .timeout_cnt_o(t_cnt)
    );

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic push(input int kind, input int port, input logic [31:0] addr,
                        input logic wr, input logic [255:0] data, input int cnt);
        ev_t e;
        e.kind = kind; e.port = port; e.addr = addr; e.wr = wr; e.data = data; e.cnt = cnt;
        sb.push_back(e);
    endtask

    task automatic pop(input int kind, output ev_t e, output bit ok);
        if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_unexpected: got event kind %0d required none", kind);
            ok = 1'b0;
        end else begin
            e  = sb.pop_front();
            chk("sb_kind", 256'(kind), 256'(e.kind));
            ok = (kind == e.kind);
        end
    endtask

    // Memory model: acks in grant cycle ack_lat (0 = never answer).
    int gcnt = 0;
    always @(posedge clk) begin
        #1;
        if (m_en) begin
            gcnt++;
            resp_ack = (ack_lat != 0) && (gcnt == ack_lat);
        end else begin
            gcnt     = 0;
            resp_ack = 1'b0;
        end
    end

    logic         prev_en = 1'b0;
    logic [255:0] cap_data;
    logic [31:0]  cap_addr;
    always @(negedge clk) begin
        ev_t e;
        bit  ok;
        if (!rst_n) begin
            prev_en = 1'b0;
        end else begin
            if (m_en && !prev_en) begin
                pop(K_G, e, ok);
                if (ok) begin
                    chk("grant_addr", 256'(m_addr), 256'(e.addr));
                    chk("grant_write", 256'(m_wr), 256'(e.wr));
                    chk("grant_data", m_wdata, e.data);
                end
                cap_data = m_wdata;
                cap_addr = m_addr;
            end else if (m_en) begin
                chk("hold_data", m_wdata, cap_data);
                chk("hold_addr", 256'(m_addr), 256'(cap_addr));
            end
            if (a0 || a1) begin
                chk("ack_onehot", 256'(a0 & a1), 256'd0);
                pop(K_A, e, ok);
                if (ok) begin
                    chk("ack_port", 256'(a1), 256'(e.port));
                    chk("ack_data", a1 ? d1 : d0, e.data);
                end
            end
            if (tmo) begin
                pop(K_T, e, ok);
                if (ok) chk("timeout_cnt", 256'(tcnt), 256'(e.cnt));
            end
            prev_en = m_en;
        end
    end

    task automatic wait_ack(input int port, input bit drop);
        int i;
        for (i = 0; i < 100; i++) begin
            @(negedge clk);
            if ((port == 0) ? a0 : a1) break;
        end
        n_chk++;
        if (i == 100) begin
            n_fail++;
            $display("FAIL wait_ack_p%0d: got no ack required ack within 100 cycles", port);
        end
        @(posedge clk);
        #1;
        if (drop) begin
            if (port == 0) p0_en = 1'b0;
            else           p1_en = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; p0_en = 0; p1_en = 0; p0_wr = 0; p1_wr = 0;
        p0_addr = 0; p1_addr = 0; p0_wdata = 0; p1_wdata = 0;
        mem_rdata = 0; stray_ack = 0; ack_lat = 0; t_en = 0; t_ack = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_enable", 256'(m_en), 256'd0);
        chk("rst_mem_write", 256'(m_wr), 256'd0);
        chk("rst_mem_addr", 256'(m_addr), 256'd0);
        chk("rst_mem_data", m_wdata, 256'd0);
        chk("rst_timeout", 256'(tmo), 256'd0);
        chk("rst_timeout_cnt", 256'(tcnt), 256'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Tie straight after reset: p0, then p1 (p0 renewed), then p0 again.
        ack_lat = 3; mem_rdata = {8{32'h1111_2222}};
        p0_addr = 32'h100; p0_wr = 0; p0_wdata = {32{8'h0F}};
        p1_addr = 32'h200; p1_wr = 1; p1_wdata = {32{8'h5A}};
        push(K_G, 0, 32'h100, 1'b0, {32{8'h0F}}, 0);
        push(K_A, 0, 0, 1'b0, {8{32'h1111_2222}}, 0);
        push(K_G, 1, 32'h200, 1'b1, {32{8'h5A}}, 0);
        push(K_A, 1, 0, 1'b0, {8{32'h1111_2222}}, 0);
        push(K_G, 0, 32'h180, 1'b0, {32{8'h0F}}, 0);
        push(K_A, 0, 0, 1'b0, {8{32'h1111_2222}}, 0);
        p0_en = 1; p1_en = 1;
        wait_ack(0, 1'b0);
        p0_addr = 32'h180;
        chk("tie_idle_gap", 256'(m_en), 256'd0);
        @(posedge clk);
        #1;
        chk("tie_p1_wins", 256'(m_addr), 256'h200);
        wait_ack(1, 1'b1);
        wait_ack(0, 1'b1);
        repeat (2) @(posedge clk);
        #1;

        // Single read from p1, acked 10 cycles after the grant.
        ack_lat = 11; mem_rdata = {4{64'hCAFE_F00D_1234_5678}};
        p1_addr = 32'h400; p1_wr = 0; p1_wdata = 256'd7;
        push(K_G, 1, 32'h400, 1'b0, 256'd7, 0);
        push(K_A, 1, 0, 1'b0, {4{64'hCAFE_F00D_1234_5678}}, 0);
        p1_en = 1;
        wait_ack(1, 1'b1);
        chk("read_idle_after", 256'(m_en), 256'd0);
        repeat (2) @(posedge clk);
        #1;

        // Requester inputs change mid-grant and must be ignored.
        ack_lat = 6; mem_rdata = 256'h1;
        p1_addr = 32'h500; p1_wr = 1; p1_wdata = {32{8'hAA}};
        push(K_G, 1, 32'h500, 1'b1, {32{8'hAA}}, 0);
        push(K_A, 1, 0, 1'b0, 256'h1, 0);
        p1_en = 1;
        repeat (2) @(posedge clk);
        #1;
        p1_wdata = {32{8'h55}}; p1_addr = 32'h999; p1_wr = 0;
        @(negedge clk);
        chk("stable_write", 256'(m_wr), 256'd1);
        chk("stable_data", m_wdata, {32{8'hAA}});
        wait_ack(1, 1'b1);
        repeat (2) @(posedge clk);
        #1;

        // Timeout at the default limit, then the retry succeeds.
        ack_lat = 0; mem_rdata = 256'h2;
        p0_addr = 32'h700; p0_wr = 0; p0_wdata = 256'd3;
        push(K_G, 0, 32'h700, 1'b0, 256'd3, 0);
        push(K_T, 0, 0, 1'b0, 0, 1);
        push(K_G, 0, 32'h700, 1'b0, 256'd3, 0);
        push(K_A, 0, 0, 1'b0, 256'h2, 0);
        p0_en = 1;
        begin
            int i;
            for (i = 0; i < 80; i++) begin
                @(negedge clk);
                if (tmo) break;
            end
            n_chk++;
            if (i == 80) begin
                n_fail++;
                $display("FAIL wait_timeout: got no timeout required pulse within 80 cycles");
            end
        end
        ack_lat = 2;
        wait_ack(0, 1'b1);
        repeat (2) @(posedge clk);
        #1;

        // Ack landing on the last allowed grant cycle is a success.
        ack_lat = 31; mem_rdata = 256'h3;
        p1_addr = 32'h800; p1_wr = 0;
        push(K_G, 1, 32'h800, 1'b0, 256'd7, 0);
        push(K_A, 1, 0, 1'b0, 256'h3, 0);
        p1_wdata = 256'd7;
        p1_en = 1;
        wait_ack(1, 1'b1);
        @(negedge clk);
        chk("boundary_no_timeout", 256'(tmo), 256'd0);
        chk("boundary_cnt", 256'(tcnt), 256'd1);

        // Stray memory ack while idle.
        @(posedge clk);
        #1;
        stray_ack = 1;
        @(negedge clk);
        chk("stray_ack0", 256'(a0), 256'd0);
        chk("stray_ack1", 256'(a1), 256'd0);
        @(posedge clk);
        #1;
        stray_ack = 0;
        chk("stray_idle", 256'(m_en), 256'd0);

        // Short-timeout instance: exact grant length, then ack on the final cycle.
        t_en = 1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t4_granted", 256'(t_men), 256'd1);
            chk("t4_no_tmo_early", 256'(t_tmo), 256'd0);
        end
        @(negedge clk);
        chk("t4_tmo_pulse", 256'(t_tmo), 256'd1);
        chk("t4_tmo_released", 256'(t_men), 256'd0);
        chk("t4_tmo_cnt", 256'(t_cnt), 256'd1);
        chk("t4_no_ack", 256'(t_a0), 256'd0);
        @(negedge clk);
        chk("t4_tmo_once", 256'(t_tmo), 256'd0);
        chk("t4_regrant", 256'(t_men), 256'd1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        t_ack = 1;
        @(negedge clk);
        chk("t4_edge_ack", 256'(t_a0), 256'd1);
        @(posedge clk);
        #1;
        t_ack = 0; t_en = 0;
        @(negedge clk);
        chk("t4_edge_no_tmo", 256'(t_tmo), 256'd0);
        chk("t4_edge_cnt", 256'(t_cnt), 256'd1);
        chk("t4_edge_idle", 256'(t_men), 256'd0);

        // Reset during a p1 grant, then a tie after release.
        ack_lat = 0;
        p1_addr = 32'h900; p1_wr = 0; p1_wdata = 256'd9;
        push(K_G, 1, 32'h900, 1'b0, 256'd9, 0);
        p1_en = 1;
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_enable", 256'(m_en), 256'd0);
        chk("midrst_ack", 256'(a1), 256'd0);
        chk("midrst_cnt", 256'(tcnt), 256'd0);
        p1_en = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ack_lat = 2; mem_rdata = 256'h4;
        p0_addr = 32'hA00; p0_wr = 0; p0_wdata = 256'd10;
        p1_addr = 32'hB00; p1_wr = 0; p1_wdata = 256'd11;
        push(K_G, 0, 32'hA00, 1'b0, 256'd10, 0);
        push(K_A, 0, 0, 1'b0, 256'h4, 0);
        push(K_G, 1, 32'hB00, 1'b0, 256'd11, 0);
        push(K_A, 1, 0, 1'b0, 256'h4, 0);
        p0_en = 1; p1_en = 1;
        wait_ack(0, 1'b1);
        wait_ack(1, 1'b1);
        repeat (3) @(posedge clk);
        #1;

        chk("sb_drained", 256'(sb.size()), 256'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: request/memory address width.
REQ-002 Parameter DATA_W, default 256: memory line width.
REQ-003 Parameter TIMEOUT, default 31: maximum cycles in a grant before the transaction is abandoned; legal range 1..255.
REQ-004 clk_i  input  1: single clock; all state updates on its rising edge.
REQ-005 rst_i  input  1: reset, asynchronous, active-low.
REQ-006 p0_enable_i  input  1: port 0 (instruction refill) request, held high until p0_ack_o.
REQ-007 p0_write_i  input  1: port 0 write (1) or read (0).
REQ-008 p0_addr_i  input  ADDR_W: port 0 line address.
REQ-009 p0_data_i  input  DATA_W: port 0 write data.
REQ-010 p0_ack_o  output  1: port 0 transaction complete.
REQ-011 p0_data_o  output  DATA_W: port 0 read data, valid only with p0_ack_o.
REQ-012 p1_enable_i, p1_write_i, p1_addr_i, p1_data_i, p1_ack_o, p1_data_o: port 1 (data cache) equivalents of REQ-006..REQ-011, same widths and directions.
REQ-013 mem_enable_o  output  1: memory request, registered.
REQ-014 mem_write_o  output  1: memory write, registered.
REQ-015 mem_addr_o  output  ADDR_W: memory address, registered.
REQ-016 mem_data_o  output  DATA_W: memory write data, registered.
REQ-017 mem_data_i  input  DATA_W: memory read data.
REQ-018 mem_ack_i  input  1: memory completion pulse.
REQ-019 timeout_o  output  1: one-cycle pulse on abandoned transaction.
REQ-020 timeout_cnt_o  output  8: saturating count of timeouts.

Function
REQ-021 FSM states SHALL be IDLE, GRANT0 and GRANT1.
REQ-022 In IDLE with any enable high, the arbiter SHALL move to the granted port's GRANT state at the next edge.
- At that edge it SHALL capture that port's write/addr/data into the mem_* registers and set mem_enable_o=1.
REQ-023 Arbitration SHALL be round-robin: on a simultaneous request, the port not granted last SHALL win; with a single request, that port SHALL win.
REQ-024 The last-granted pointer SHALL update on entry to a GRANT state.
REQ-025 In GRANTn, mem_* outputs SHALL hold stable; requester input changes SHALL be ignored.
REQ-026 pn_ack_o SHALL equal mem_ack_i AND (state==GRANTn), combinationally; the other port's ack SHALL stay 0.
REQ-027 p0_data_o and p1_data_o SHALL both equal mem_data_i; they are meaningful only with the matching ack.
REQ-028 On mem_ack_i in GRANTn, the next state SHALL be IDLE with mem_enable_o=0.
- Every transaction is followed by at least one IDLE cycle.
- A requester SHALL drop or renew its enable the cycle after ack.
REQ-029 mem_ack_i in IDLE SHALL be ignored: no ack output and no state change.
REQ-030 A cycle counter SHALL clear on GRANT entry and increment each GRANT cycle without ack.
- When it reaches TIMEOUT with no ack: next state IDLE, mem_enable_o=0, timeout_o pulsed for one cycle, timeout_cnt_o incremented (saturating at 255), no ack to the requester.
- A requester still holding enable is then re-arbitrated normally.
REQ-031 An ack arriving in the same cycle the counter reaches TIMEOUT SHALL count as success: ack delivered, no timeout.
REQ-032 Grant latency SHALL be 1 cycle from enable seen in IDLE to mem_enable_o high.
- Ack to requester is 0 cycles after mem_ack_i.

Reset
REQ-033 On rst_i low, asynchronously: state IDLE; all mem_* outputs 0; timeout_o 0; timeout_cnt_o 0; counter 0; pointer set so port 0 wins the first tie.
REQ-034 A reset asserted mid-transaction SHALL abandon it with no ack and no timeout count.
REQ-035 Operation SHALL resume on the first rising edge after rst_i goes high.

Verification
REQ-036 Single read: p1 read addr 0x400 only, memory acks 10 cycles after mem_enable_o -> mem_addr_o=0x400, mem_write_o=0, p1_ack_o pulses with mem_data_i, p0_ack_o stays 0, IDLE next.
REQ-037 Tie after reset: p0 and p1 assert together -> p0 granted first; p1 granted after p0 ack plus one IDLE cycle; next tie -> p1 wins.
REQ-038 Input stability: p1 write data 0xAA..AA granted, then p1_data_i changed mid-grant -> mem_data_o stays 0xAA..AA until ack.
REQ-039 Timeout, TIMEOUT=4, no ack -> timeout_o pulses once after 4 GRANT cycles, timeout_cnt_o=1, no ack to the requester, same port re-granted on the retry.
REQ-040 Boundary: ack on exactly the TIMEOUT cycle -> ack delivered, timeout_cnt_o unchanged; stray mem_ack_i in IDLE -> no effect.
REQ-041 Reset mid-grant: rst_i low during GRANT1 -> mem_enable_o=0 immediately, no ack, timeout_cnt_o=0; a p0/p1 tie after release -> p0 wins.
